aes_iter_cipher: RTL

- Iterative AES encryption core, one round per clock, parametrised for AES-128 or AES-256.
- Successor to the single-shot combinational cipher. Adds a valid/ready handshake on input and output, back-to-back block acceptance, and a configurable key size.
- Sits between the block source (UART/stream framer) and the ciphertext sink.
- Byte order follows FIPS-197: datain[127:120] is state byte 0, column-major.

---
 rtl/aes_iter_cipher_if.sv | 24 ++
 rtl/aes_iter_cipher.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_iter_cipher_if.sv
// Block/ciphertext handshake bundle for aes_iter_cipher.
// The source/sink side uses the master modport, and the cipher core uses the slave modport.
interface aes_iter_cipher_if #(
    parameter int KEY_BITS = 128
);
    logic                in_valid;
    logic                in_ready;
    logic [127:0]        datain;
    logic [KEY_BITS-1:0] key;
    logic                out_valid;
    logic                out_ready;
    logic [127:0]        dataout;
    logic                busy;

    modport master (
        output in_valid, datain, key, out_ready,
        input  in_ready, out_valid, dataout, busy
    );

    modport slave (
        input  in_valid, datain, key, out_ready,
        output in_ready, out_valid, dataout, busy
    );
endinterface

// File: rtl/aes_iter_cipher.sv
// Iterative AES-128/256 encryptor: one round per clock, with the key schedule generated on the fly.
// Optional AES_ZEROIZE_EN clears the datapath registers on reset and on every output handshake.
module aes_iter_cipher #(
    parameter int KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         rst,
    aes_iter_cipher_if.slave bus
);
    localparam int         NR   = (KEY_BITS == 256) ? 14 : 10;
    localparam logic [3:0] NR_L = 4'(NR);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_badKeyBits
            $error("aes_iter_cipher: KEY_BITS must be 128 or 256");
        end
    endgenerate

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t              r_state, w_nextState;
    logic [3:0]          r_rcnt;
    logic [127:0]        r_block;
    logic [KEY_BITS-1:0] r_win;
    logic [127:0]        r_dataout;
    logic                r_outValid;

    logic                w_inReady, w_busy, w_accept, w_handshake, w_lastRound;
    logic [127:0]        w_roundKey, w_roundOut;
    logic [KEY_BITS-1:0] w_nextWin;
    logic [31:0]         w_temp, w_n0, w_n1, w_n2, w_n3;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixColumn(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte i of the state is row (i % 4), column (i / 4); ShiftRows rotates row r left by r.
    function automatic logic [127:0] aesRound(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [31:0]  col;
        logic [127:0] res;
        res = '0;
        for (int i = 0; i < 16; i++) sb[i] = sbox(s[127 - 8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sr[r + 4*c] = sb[r + 4*((c + r) % 4)];
        for (int c = 0; c < 4; c++) begin
            col = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
            res[127 - 32*c -: 32] = last ? col : mixColumn(col);
        end
        return res ^ rk;
    endfunction

    // The AES-128 window holds the previous round key and the AES-256 window holds the previous eight words.
    generate
        if (KEY_BITS == 256) begin : g_sched256
            always_comb begin
                w_temp = r_rcnt[0] ? (subWord({r_win[23:0], r_win[31:24]}) ^
                                      {rcon(4'(r_rcnt + 4'd1) >> 1), 24'h0})
                                   : subWord(r_win[31:0]);
                w_n0 = r_win[255:224] ^ w_temp;
                w_n1 = r_win[223:192] ^ w_n0;
                w_n2 = r_win[191:160] ^ w_n1;
                w_n3 = r_win[159:128] ^ w_n2;
                w_roundKey = r_win[127:0];
                w_nextWin  = {r_win[127:0], w_n0, w_n1, w_n2, w_n3};
            end
        end else begin : g_sched128
            always_comb begin
                w_temp = subWord({r_win[23:0], r_win[31:24]}) ^ {rcon(r_rcnt), 24'h0};
                w_n0 = r_win[127:96] ^ w_temp;
                w_n1 = r_win[95:64]  ^ w_n0;
                w_n2 = r_win[63:32]  ^ w_n1;
                w_n3 = r_win[31:0]   ^ w_n2;
                w_roundKey = {w_n0, w_n1, w_n2, w_n3};
                w_nextWin  = w_roundKey;
            end
        end
    endgenerate

    assign w_lastRound = (r_rcnt == NR_L);
    assign w_roundOut  = aesRound(r_block, w_roundKey, w_lastRound);
    assign w_accept    = bus.in_valid && w_inReady;
    assign w_handshake = (r_state == DONE) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = ROUND;
            ROUND:   if (w_lastRound) w_nextState = DONE;
            DONE:    if (bus.out_ready) w_nextState = w_accept ? ROUND : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_inReady = 1'b0;
        w_busy    = 1'b0;
        case (r_state)
            IDLE:    w_inReady = !rst;
            ROUND:   w_busy    = 1'b1;
            DONE:    w_inReady = !rst && bus.out_ready;
            default: w_inReady = 1'b0;
        endcase
    end

    // A same-edge accept is written last, so it overrides any handshake-time zeroization of the datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rcnt     <= 4'd0;
            r_outValid <= 1'b0;
            r_dataout  <= '0;
`ifdef AES_ZEROIZE_EN
            r_block    <= '0;
            r_win      <= '0;
`endif
        end else begin
            if (w_handshake) begin
                r_outValid <= 1'b0;
`ifdef AES_ZEROIZE_EN
                r_dataout  <= '0;
                r_block    <= '0;
                r_win      <= '0;
`endif
            end
            if (w_accept) begin
                r_block <= bus.datain ^ bus.key[KEY_BITS-1 -: 128];
                r_win   <= bus.key;
                r_rcnt  <= 4'd1;
            end else if (r_state == ROUND) begin
                r_block <= w_roundOut;
                r_win   <= w_nextWin;
                if (w_lastRound) begin
                    r_rcnt     <= 4'd0;
                    r_dataout  <= w_roundOut;
                    r_outValid <= 1'b1;
                end else begin
                    r_rcnt <= r_rcnt + 4'd1;
                end
            end
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.busy      = w_busy;
    assign bus.out_valid = r_outValid;
    assign bus.dataout   = r_dataout;
endmodule
